// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// FSM state encodings and address-decode helpers.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Registers are 32-bit words; the two byte-offset bits are ignored.
  localparam int ADDR_LSB = 2;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

  // Result of decoding a word index against the address map.
  typedef enum logic [1:0] {
    DEC_REG,
    DEC_STATUS,
    DEC_BAD
  } dec_e;

  // Writes succeed only into R/W registers; reads fail only outside the map.
  function automatic logic [1:0] resp_for(input dec_e kind, input logic is_write);
    if (is_write) return (kind == DEC_REG) ? RESP_OKAY : RESP_SLVERR;
    return (kind == DEC_BAD) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between an initiator (master) and this register slave.
interface axi_lite_reg_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

endinterface

// File: rtl/axi_lite_reg_bank.sv
// Register array with byte-strobed synchronous write, a combinational read
// port and a flat view of all registers for fabric-side outputs.
module axi_lite_reg_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       we,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] regs_out
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Clear on reset, otherwise merge the strobed bytes into the target word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read port sees the pre-write value during a same-cycle write.
  assign rdata = mem[rd_idx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[DATA_W*g +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave over a small register bank plus one read-only status word.
// Write and read paths run independently; AW and W may arrive in any order.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  axi_lite_reg_slave_if.slave        bus,
  input  logic [DATA_W-1:0]          status_in,
  output logic [NUM_REGS*DATA_W-1:0] regs_out
);

  localparam int RIDX_W = $clog2(NUM_REGS);
  localparam int WIDX_W = ADDR_W - ADDR_LSB;
  localparam logic [WIDX_W-1:0] NUM_REGS_W = WIDX_W'(NUM_REGS);

  // Classify a full word index: register, status word, or outside the map.
  function automatic dec_e decode(input logic [WIDX_W-1:0] widx);
    if (widx < NUM_REGS_W)  return DEC_REG;
    if (widx == NUM_REGS_W) return DEC_STATUS;
    return DEC_BAD;
  endfunction

  // Byte-offset bits carry no meaning in a word-addressed map.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.s_awaddr[ADDR_LSB-1:0], bus.s_araddr[ADDR_LSB-1:0]};

  // ---------------- write path ----------------
  wr_state_e           wr_state;
  logic                aw_held, w_held;
  logic [WIDX_W-1:0]   awidx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;

  logic                aw_hs, w_hs, wr_fire, bank_we;
  logic [WIDX_W-1:0]   wr_widx;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  dec_e                wr_kind;

  assign bus.s_awready = !aw_held && !bvalid_q;
  assign bus.s_wready  = !w_held && !bvalid_q;
  assign aw_hs         = bus.s_awvalid && bus.s_awready;
  assign w_hs          = bus.s_wvalid && bus.s_wready;

  // A channel counts as available if already held or handshaking right now.
  assign wr_widx = aw_held ? awidx_q : bus.s_awaddr[ADDR_W-1:ADDR_LSB];
  assign wr_data = w_held ? wdata_q : bus.s_wdata;
  assign wr_strb = w_held ? wstrb_q : bus.s_wstrb;
  assign wr_kind = decode(wr_widx);
  assign wr_fire = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign bank_we = wr_fire && (wr_kind == DEC_REG);

  assign bus.s_bvalid = bvalid_q;
  assign bus.s_bresp  = bresp_q;

  // Write FSM: track held channels, commit once both present, wait for B.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) aw_held <= 1'b1;
          if (w_hs)  w_held  <= 1'b1;
          if (wr_fire) begin
            aw_held  <= 1'b1;
            w_held   <= 1'b1;
            bvalid_q <= 1'b1;
            bresp_q  <= resp_for(wr_kind, 1'b1);
            wr_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid_q && bus.s_bready) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b0;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Capture address and data of whichever channel handshakes first.
  always_ff @(posedge clk) begin
    if (aw_hs) awidx_q <= bus.s_awaddr[ADDR_W-1:ADDR_LSB];
    if (w_hs) begin
      wdata_q <= bus.s_wdata;
      wstrb_q <= bus.s_wstrb;
    end
  end

  // ---------------- read path ----------------
  rd_state_e         rd_state;
  logic              arready_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic              ar_hs;
  logic [WIDX_W-1:0] rd_widx;
  dec_e              rd_kind;
  logic [DATA_W-1:0] bank_rdata, rd_word;

  assign ar_hs   = bus.s_arvalid && arready_q;
  assign rd_widx = bus.s_araddr[ADDR_W-1:ADDR_LSB];
  assign rd_kind = decode(rd_widx);

  // Select the word a read would return: register, status, or zero.
  always_comb begin
    rd_word = '0;
    case (rd_kind)
      DEC_REG:    rd_word = bank_rdata;
      DEC_STATUS: rd_word = status_in;
      default:    rd_word = '0;
    endcase
  end

  assign bus.s_arready = arready_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rdata   = rdata_q;

  // Read FSM: latch data on AR handshake, hold it until R handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state  <= RD_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rd_word;
            rresp_q   <= resp_for(rd_kind, 1'b0);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rd_state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid_q && bus.s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  axi_lite_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (RIDX_W)
  ) u_bank (
    .clk      (clk),
    .resetn   (resetn),
    .we       (bank_we),
    .wr_idx   (wr_widx[RIDX_W-1:0]),
    .wdata    (wr_data),
    .wstrb    (wr_strb),
    .rd_idx   (rd_widx[RIDX_W-1:0]),
    .rdata    (bank_rdata),
    .regs_out (regs_out)
  );

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: a vector table of single read/write
// transactions plus hand-written sequences for ordering, stall and reset cases.
module tb_axi_lite_reg_slave;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   status_in = 32'hA5A5A5A5;
  logic [127:0]  regs_out;

  axi_lite_reg_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_reg_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .status_in (status_in),
    .regs_out  (regs_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    bit hs;
    int n;
    bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = s;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_bready = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      hs = bus.s_awready && bus.s_wready;
      tick();
      n++;
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("wr_handshake", 64'(hs), 64'd1);
    chk("wr_bvalid_latency", 64'(bus.s_bvalid), 64'd1);
    resp = bus.s_bresp;
    tick();
    chk("wr_bvalid_clear", 64'(bus.s_bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs;
    int n;
    bus.s_araddr = a; bus.s_arvalid = 1'b1; bus.s_rready = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      hs = bus.s_arready;
      tick();
      n++;
    end
    bus.s_arvalid = 1'b0;
    chk("rd_handshake", 64'(hs), 64'd1);
    chk("rd_rvalid_latency", 64'(bus.s_rvalid), 64'd1);
    d = bus.s_rdata;
    resp = bus.s_rresp;
    tick();
    chk("rd_rvalid_clear", 64'(bus.s_rvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, r0;
    bit          ok;
    int          bcnt;

    // Register state after the hand sequences that precede the table:
    // reg0=FFFF5678, reg1=0, reg2=00000001, reg3=0.
    vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0C, 32'h0000AA55, 4'h1, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h00000055};
    vecs[4]  = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5};
    vecs[5]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    vecs[6]  = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5};
    vecs[7]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[8]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 2'b10, 32'h0};
    vecs[9]  = '{1'b0, 32'h06, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 32'h08, 32'h11223344, 4'hC, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'h11220001};
    vecs[12] = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'hFFFF5678};
    vecs[13] = '{1'b1, 32'h01, 32'hAABBCCDD, 4'h2, 2'b00, 32'h0};
    vecs[14] = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'hFFFFCC78};
    vecs[15] = '{1'b0, 32'h14, 32'h0,        4'h0, 2'b10, 32'h0};

    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;

    // Reset and check idle state
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    chk("rst_bvalid",  64'(bus.s_bvalid),  64'd0);
    chk("rst_rvalid",  64'(bus.s_rvalid),  64'd0);
    chk("rst_bresp",   64'(bus.s_bresp),   64'd0);
    chk("rst_rresp",   64'(bus.s_rresp),   64'd0);
    chk("rst_rdata",   64'(bus.s_rdata),   64'd0);
    chk("rst_awready", 64'(bus.s_awready), 64'd1);
    chk("rst_wready",  64'(bus.s_wready),  64'd1);
    chk("rst_arready", 64'(bus.s_arready), 64'd1);
    chk("rst_regs_lo", regs_out[63:0],   64'd0);
    chk("rst_regs_hi", regs_out[127:64], 64'd0);

    // Concurrent write and read of reg2: read must see the old value
    bus.s_awaddr = 32'h8; bus.s_wdata = 32'h1; bus.s_wstrb = 4'hF;
    bus.s_araddr = 32'h8;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    chk("conc_bvalid", 64'(bus.s_bvalid), 64'd1);
    chk("conc_rvalid", 64'(bus.s_rvalid), 64'd1);
    chk("conc_rdata_old", 64'(bus.s_rdata), 64'h0);
    chk("conc_reg2", 64'(regs_out[95:64]), 64'h1);
    tick();
    do_read(32'h8, rd, rs);
    chk("conc_reread", 64'(rd), 64'h1);

    // W three cycles ahead of AW, strobes 0x3 over all-ones
    do_write(32'h0, 32'hFFFFFFFF, 4'hF, rs);
    chk("pre_resp", 64'(rs), 64'd0);
    bus.s_wdata = 32'h12345678; bus.s_wstrb = 4'h3; bus.s_wvalid = 1'b1; bus.s_bready = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    chk("wfirst_wready_held", 64'(bus.s_wready), 64'd0);
    chk("wfirst_awready", 64'(bus.s_awready), 64'd1);
    tick(); tick();
    chk("wfirst_no_b", 64'(bus.s_bvalid), 64'd0);
    bus.s_awaddr = 32'h0; bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    chk("wfirst_bvalid", 64'(bus.s_bvalid), 64'd1);
    chk("wfirst_bresp", 64'(bus.s_bresp), 64'd0);
    chk("wfirst_reg0", 64'(regs_out[31:0]), 64'hFFFF5678);
    bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.s_bvalid) bcnt++;
    end
    chk("wfirst_single_b", 64'(bcnt), 64'd0);

    // Table-driven single transactions
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
        chk($sformatf("vec%0d_bresp", i), 64'(rs), 64'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, rd, rs);
        chk($sformatf("vec%0d_rresp", i), 64'(rs), 64'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      end
    end
    chk("tbl_reg0", 64'(regs_out[31:0]),   64'hFFFFCC78);
    chk("tbl_reg1", 64'(regs_out[63:32]),  64'hDEADBEEF);
    chk("tbl_reg2", 64'(regs_out[95:64]),  64'h11220001);
    chk("tbl_reg3", 64'(regs_out[127:96]), 64'h00000055);

    // B channel back-pressure: response held, second write blocked
    bus.s_bready = 1'b0;
    bus.s_awaddr = 32'h4; bus.s_wdata = 32'h0BADF00D; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    tick();
    chk("stall_bvalid", 64'(bus.s_bvalid), 64'd1);
    r0 = bus.s_bresp;
    chk("stall_bresp", 64'(r0), 64'd0);
    bus.s_awaddr = 32'hC; bus.s_wdata = 32'h00000077;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(bus.s_bvalid && bus.s_bresp == r0 && !bus.s_awready && !bus.s_wready)) ok = 1'b0;
    end
    chk("stall_stable", 64'(ok), 64'd1);
    chk("stall_reg1", 64'(regs_out[63:32]), 64'h0BADF00D);
    chk("stall_reg3_untouched", 64'(regs_out[127:96]), 64'h00000055);
    bus.s_bready = 1'b1;
    tick();
    chk("stall_b_done", 64'(bus.s_bvalid), 64'd0);
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("second_bvalid", 64'(bus.s_bvalid), 64'd1);
    chk("second_reg3", 64'(regs_out[127:96]), 64'h00000077);
    tick();
    chk("second_b_done", 64'(bus.s_bvalid), 64'd0);

    // Reset while a read response is pending
    bus.s_rready = 1'b0;
    bus.s_araddr = 32'h4; bus.s_arvalid = 1'b1;
    tick();
    bus.s_arvalid = 1'b0;
    chk("pend_rvalid", 64'(bus.s_rvalid), 64'd1);
    chk("pend_rdata", 64'(bus.s_rdata), 64'h0BADF00D);
    tick();
    chk("pend_rvalid_hold", 64'(bus.s_rvalid), 64'd1);
    resetn = 1'b0;
    tick();
    chk("mrst_rvalid", 64'(bus.s_rvalid), 64'd0);
    chk("mrst_rdata", 64'(bus.s_rdata), 64'd0);
    chk("mrst_regs_lo", regs_out[63:0], 64'd0);
    chk("mrst_regs_hi", regs_out[127:64], 64'd0);
    resetn = 1'b1;
    chk("mrst_arready", 64'(bus.s_arready), 64'd1);
    chk("mrst_awready", 64'(bus.s_awready), 64'd1);
    chk("mrst_wready",  64'(bus.s_wready),  64'd1);
    do_read(32'h4, rd, rs);
    chk("post_rst_read", 64'(rd), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
